// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared reflected-Gray helpers for counters, converters and their benches
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Zero-extended operands decode/encode to zero-extended results, so one
    // widest-case word serves every narrower width without a width argument.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic gray_word_t all_ones(input int w);
        return (gray_word_t'(1) << w) - gray_word_t'(1);
    endfunction

    function automatic gray_word_t zero(input int w);
        return gray_word_t'(0) & all_ones(w);
    endfunction

endpackage

// File: rtl/gray_to_bin_comb.sv
// rtl/gray_to_bin_comb.sv - combinational reflected-Gray to binary decoder
module gray_to_bin_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    gray_word_t gray_ext;
    gray_word_t bin_ext;

    always_comb begin
        gray_ext = GRAY_MAX_W'(gray);
        bin_ext  = gray2bin(gray_ext);
        bin      = WIDTH'(bin_ext);
    end

endmodule

// File: rtl/gray_ptr_counter.sv
// rtl/gray_ptr_counter.sv - registered up/down counter with binary and Gray outputs in lock-step
module gray_ptr_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES  = WIDTH'(all_ones(WIDTH));
    localparam logic [WIDTH-1:0] ZERO      = WIDTH'(zero(WIDTH));
    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(INIT_BIN)));

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;

    gray_to_bin_comb #(
        .WIDTH(WIDTH)
    ) u_load_dec (
        .gray(load_gray),
        .bin (load_bin)
    );

    // Carry/borrow out of the step is dropped here and surfaces only as wrap.
    always_comb begin
        next_bin  = up ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));
        next_gray = WIDTH'(bin2gray(GRAY_MAX_W'(next_bin)));
        next_wrap = up ? (bin_out == ALL_ONES) : (bin_out == ZERO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out  <= INIT_BIN;
            gray_out <= INIT_GRAY;
            wrap     <= 1'b0;
        end else if (load) begin
            bin_out  <= load_bin;
            gray_out <= load_gray;
            wrap     <= 1'b0;
        end else if (en) begin
            bin_out  <= next_bin;
            gray_out <= next_gray;
            wrap     <= next_wrap;
        end else begin
            wrap     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_ptr_counter.sv
// tb/tb_gray_ptr_counter.sv - scoreboard bench for gray_ptr_counter
module tb_gray_ptr_counter;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_gray = 4'b0000;
    logic [3:0] bin_out, gray_out, bin3, gray3;
    logic       wrap, wrap3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      nm;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
        bit         step;
        bit         c3;
        logic [3:0] bin3;
        logic [3:0] gray3;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    gray_ptr_counter #(.WIDTH(4), .INIT(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
    );

    gray_ptr_counter #(.WIDTH(4), .INIT(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .bin_out(bin3), .gray_out(gray3), .wrap(wrap3)
    );

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return 4'(bin2gray(GRAY_MAX_W'(b)));
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return 4'(gray2bin(GRAY_MAX_W'(g)));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic [3:0] lg, input logic [3:0] eb, input logic [3:0] eg,
                         input logic ew, input bit c3, input logic [3:0] eb3,
                         input logic [3:0] eg3, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_gray = lg;
        x.nm = nm; x.bin = eb; x.gray = eg; x.wrap = ew;
        x.step = e && !l && !r;
        x.c3 = c3; x.bin3 = eb3; x.gray3 = eg3;
        sb.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is retired per edge.
    initial begin
        exp_t e;
        logic [3:0] prev_gray;
        prev_gray = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.nm, "_bin"}, 32'(bin_out), 32'(e.bin));
                check({e.nm, "_gray"}, 32'(gray_out), 32'(e.gray));
                check({e.nm, "_wrap"}, 32'(wrap), 32'(e.wrap));
                check({e.nm, "_inv"}, 32'(gray_out), 32'(b2g(bin_out)));
                if (e.step)
                    check({e.nm, "_hamming"}, 32'($countones(prev_gray ^ gray_out)), 32'd1);
                if (e.c3) begin
                    check({e.nm, "_bin3"}, 32'(bin3), 32'(e.bin3));
                    check({e.nm, "_gray3"}, 32'(gray3), 32'(e.gray3));
                    check({e.nm, "_wrap3"}, 32'(wrap3), 32'd0);
                end
                prev_gray = gray_out;
            end
        end
    end

    initial begin
        logic [3:0] gseq [16];
        logic [3:0] m_bin;
        logic       m_wrap;
        logic       r, e, u, l;
        logic [3:0] lg;
        int         wait_cycles;

        gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        drive(1, 0, 0, 0, 4'h0, 4'h0, 4'b0000, 0, 1, 4'h3, 4'b0010, "reset0");
        drive(1, 0, 0, 0, 4'h0, 4'h0, 4'b0000, 0, 1, 4'h3, 4'b0010, "reset1");
        for (int k = 1; k <= 16; k++)
            drive(0, 1, 1, 0, 4'h0, 4'(k), gseq[k % 16], (k == 16), 0, 4'h0, 4'h0, "count_up");

        drive(1, 0, 0, 0, 4'h0, 4'h0, 4'b0000, 0, 0, 4'h0, 4'h0, "reset2");
        drive(0, 1, 0, 0, 4'h0, 4'hF, 4'b1000, 1, 0, 4'h0, 4'h0, "down_wrap");
        drive(0, 1, 0, 0, 4'h0, 4'hE, 4'b1001, 0, 0, 4'h0, 4'h0, "down_next");
        drive(0, 1, 0, 0, 4'h0, 4'hD, 4'b1011, 0, 0, 4'h0, 4'h0, "down_more");

        drive(0, 0, 0, 1, 4'b1101, 4'b1001, 4'b1101, 0, 0, 4'h0, 4'h0, "load_1101");
        drive(0, 1, 1, 0, 4'h0, 4'b1010, 4'b1111, 0, 0, 4'h0, 4'h0, "load_then_up");
        drive(0, 1, 1, 1, 4'b0110, 4'b0100, 4'b0110, 0, 0, 4'h0, 4'h0, "load_with_en");

        drive(0, 0, 0, 1, 4'b0000, 4'h0, 4'b0000, 0, 0, 4'h0, 4'h0, "load_zero");
        drive(0, 1, 0, 0, 4'h0, 4'hF, 4'b1000, 1, 0, 4'h0, 4'h0, "wrap_again");
        drive(0, 1, 0, 1, 4'b1000, 4'hF, 4'b1000, 0, 0, 4'h0, 4'h0, "load_clears_wrap");
        drive(0, 1, 1, 0, 4'h0, 4'h0, 4'b0000, 1, 0, 4'h0, 4'h0, "up_wrap");
        drive(0, 0, 1, 0, 4'h0, 4'h0, 4'b0000, 0, 0, 4'h0, 4'h0, "hold_clears_wrap");

        drive(0, 0, 0, 1, 4'b0111, 4'b0101, 4'b0111, 0, 0, 4'h0, 4'h0, "load_0111");
        for (int k = 0; k < 3; k++)
            drive(0, 0, 1'(k), 0, 4'h0, 4'b0101, 4'b0111, 0, 0, 4'h0, 4'h0, "hold");
        drive(1, 1, 1, 1, 4'b1111, 4'h0, 4'b0000, 0, 1, 4'b0011, 4'b0010, "reset_mid");

        m_bin = 4'h0;
        for (int k = 0; k < 2000; k++) begin
            r  = ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            lg = 4'($urandom_range(0, 15));
            if (r) begin
                m_bin = 4'h0; m_wrap = 1'b0;
            end else if (l) begin
                m_bin = g2b(lg); m_wrap = 1'b0;
            end else if (e) begin
                m_wrap = u ? (m_bin == 4'hF) : (m_bin == 4'h0);
                m_bin  = u ? m_bin + 4'h1 : m_bin - 4'h1;
            end else begin
                m_wrap = 1'b0;
            end
            drive(r, e, u, l, lg, m_bin, b2g(m_bin), m_wrap, r, 4'h3, 4'b0010, "soak");
        end

        @(negedge clk);
        rst = 0; en = 0; load = 0;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
